// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment display constants and hex glyph table
// Active-low {dp,g,f,e,d,c,b,a} encodings for common-anode displays.
package seg7_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] ANODE_OFF  = 4'b1111;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // g..a all off; used when a leading-zero digit is suppressed
  localparam logic [6:0] SEG7_OFF = 7'h7F;

  typedef logic [1:0] digit_idx_t;

  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational nibble to active-low g..a pattern
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  logic [7:0] glyph;

  always_comb begin
    glyph   = hex_glyph(nibble);
    pattern = glyph[6:0];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed common-anode 7-segment driver
// Optional LEADING_ZERO_BLANK_EN: suppress leading zero digits 3..1.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  output logic [3:0]  anode,
  output logic [7:0]  seg,
  output logic        frame_start
);

  localparam int              CW         = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]   CNT_MAX    = CW'(REFRESH_DIV - 1);
  localparam digit_idx_t      LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt;
  digit_idx_t    idx;
  logic [15:0]   shadow;
  logic          load_pending;

  logic          tick;
  logic          load;
  logic [3:0]    nibble;
  logic [6:0]    pattern;
  logic          blank;
  logic [3:0]    anode_next;
  logic [7:0]    seg_next;

  assign tick = (cnt == CNT_MAX);
  // Shadow reloads only at the frame boundary so a frame never mixes two values
  assign load = load_pending | (tick && (idx == LAST_DIGIT));

  assign nibble = shadow[{idx, 2'b00} +: 4];

  seg7_hex_decode u_decode (
    .nibble  (nibble),
    .pattern (pattern)
  );

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    blank = 1'b0;
    case (idx)
      2'd3:    blank = (shadow[15:12] == 4'h0);
      2'd2:    blank = (shadow[15:8]  == 8'h00);
      2'd1:    blank = (shadow[15:4]  == 12'h000);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    anode_next = ~(4'b0001 << idx) | ~digit_en;
    seg_next   = {~dp_in[idx], (blank ? SEG7_OFF : pattern)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      idx          <= '0;
      shadow       <= 16'h0000;
      load_pending <= 1'b1;
      anode        <= ANODE_OFF;
      seg          <= SEG_BLANK;
      frame_start  <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        idx <= idx + 2'd1;
      end
      if (load) begin
        shadow       <= value;
        load_pending <= 1'b0;
      end
      frame_start <= load;
      anode       <= anode_next;
      seg         <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver (REFRESH_DIV=4)
// Honours LEADING_ZERO_BLANK_EN when defined for the build.
module tb_seg7_scan_driver;

  typedef struct packed {
    logic [3:0] anode;
    logic [7:0] seg;
    logic       fs;
  } exp_t;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic [15:0] value    = 16'h0000;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  dp_in    = 4'h0;
  logic [3:0]  anode;
  logic [7:0]  seg;
  logic        frame_start;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  localparam logic [15:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .digit_en    (digit_en),
    .dp_in       (dp_in),
    .anode       (anode),
    .seg         (seg),
    .frame_start (frame_start)
  );

  task automatic check(input string nm, input exp_t act, input exp_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got anode=%b seg=%h fs=%b, required anode=%b seg=%h fs=%b",
               nm, act.anode, act.seg, act.fs, exp.anode, exp.seg, exp.fs);
    end
  endtask

  // Monitor: one expectation consumed per sampled cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {anode, seg, frame_start};
      check(nm, a, e);
    end
  end

  task automatic step(input string nm, input logic [3:0] a, input logic [7:0] s, input logic f);
    @(posedge clk);
    #1;
    exp_q.push_back({a, s, f});
    name_q.push_back(nm);
  endtask

  // A frame is 16 cycles; the last one carries the frame_start of the next reload
  task automatic run_frame(input string nm, input logic [15:0] an, input logic [31:0] sg,
                           input int first, input int last);
    for (int c = first; c < last; c++) begin
      step($sformatf("%s[%0d]", nm, c), an[(c/4)*4 +: 4], sg[(c/4)*8 +: 8], c == 15);
    end
  endtask

  initial begin
    value = 16'h1234;
    for (int i = 0; i < 10; i++) step($sformatf("reset[%0d]", i), 4'b1111, 8'hFF, 1'b0);
    reset = 1'b0;

    // first cycle after release: load pulse, digit 0 still showing the cleared shadow
    step("first_load", 4'b1110, 8'hC0, 1'b1);
    run_frame("f1234", AN_ALL, {8'hF9, 8'hA4, 8'hB0, 8'h99}, 1, 16);

    run_frame("f1234_mid", AN_ALL, {8'hF9, 8'hA4, 8'hB0, 8'h99}, 0, 6);
    value = 16'hABCD;
    run_frame("f1234_mid", AN_ALL, {8'hF9, 8'hA4, 8'hB0, 8'h99}, 6, 16);

    run_frame("fABCD", AN_ALL, {8'h88, 8'h83, 8'hC6, 8'hA1}, 0, 3);
    value = 16'h000F;
    run_frame("fABCD", AN_ALL, {8'h88, 8'h83, 8'hC6, 8'hA1}, 3, 16);

    run_frame("f000F", AN_ALL, {LZ, LZ, LZ, 8'h8E}, 0, 2);
    value = 16'hABCD;
    run_frame("f000F", AN_ALL, {LZ, LZ, LZ, 8'h8E}, 2, 16);

    digit_en = 4'b0101;
    dp_in    = 4'b0001;
    run_frame("fen_dp", {4'b1111, 4'b1011, 4'b1111, 4'b1110},
              {8'h88, 8'h83, 8'hC6, 8'h21}, 0, 16);
    digit_en = 4'hF;
    dp_in    = 4'h0;

    value = 16'h5678;
    run_frame("fpre_rst", AN_ALL, {8'h88, 8'h83, 8'hC6, 8'hA1}, 0, 10);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset", {anode, seg, frame_start}, {4'b1111, 8'hFF, 1'b0});
    for (int i = 0; i < 3; i++) step($sformatf("rst2[%0d]", i), 4'b1111, 8'hFF, 1'b0);
    reset = 1'b0;
    step("reload", 4'b1110, 8'hC0, 1'b1);
    run_frame("f5678", AN_ALL, {8'h92, 8'h82, 8'hF8, 8'h80}, 1, 16);

    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
